// File: rtl/stage_ma_pkg.sv
// -----------------------------------------------------------------------------
// stage_ma_pkg
// Types shared by the memory-access stage and its neighbours:
//   ex_ma_reg_t : EX-MA pipeline register consumed by stage_ma
//   ma_wb_reg_t : MA-WB pipeline register produced by stage_ma
//   ma_state_e  : access FSM state encoding
// -----------------------------------------------------------------------------
package stage_ma_pkg;

    typedef struct packed {
        logic        instr_valid;
        logic [31:0] pc_plus_four;
        logic [31:0] alu_result;
        logic        dmem_rd_en;
        logic        dmem_wr_en;
        logic [1:0]  dmem_size;    // 00 byte, 01 half, 1x word
        logic        dmem_sign;    // 1 = zero-extend (LBU/LHU)
        logic [31:0] dmem_wdata;
        logic        reg_wr_en;
        logic [4:0]  reg_wr_addr;
    } ex_ma_reg_t;

    typedef struct packed {
        logic        instr_valid;
        logic [31:0] pc_plus_four;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic        reg_wr_en;
        logic [4:0]  reg_wr_addr;
    } ma_wb_reg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } ma_state_e;

endpackage

// File: rtl/stage_ma.sv
// -----------------------------------------------------------------------------
// stage_ma
// Memory-access stage of the 5-stage RISC-V pipeline. Issues load/store
// requests on a valid/ready data-memory port, formats store byte lanes,
// aligns and extends load data, and registers the result into MA-WB.
// stall_o freezes IF..EX while an access is outstanding.
//
// Parameters:
//   RSP_TIMEOUT : cycles to wait for a load response, 0 = wait forever
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses issue no request, are forwarded
//               with reg_wr_en=0 and pulse dmem_err_o
//   undefined : low address bits are masked to natural alignment
//
// Ports:
//   clk, rst_ni        clock / asynchronous active-low reset
//   ex_ma_i            EX-MA pipeline register
//   ma_wb_reg_o        MA-WB pipeline register
//   stall_o            access incomplete, hold EX-MA and upstream
//   dmem_req_valid_o   request valid
//   dmem_req_ready_i   memory accepts request
//   dmem_we_o          1 = store, 0 = load
//   dmem_addr_o        word-aligned address
//   dmem_be_o          byte enables
//   dmem_wdata_o       lane-replicated store data
//   dmem_rsp_valid_i   load response valid
//   dmem_rdata_i       load response word
//   dmem_err_o         1-cycle pulse on timeout or misaligned trap
// -----------------------------------------------------------------------------
module stage_ma
    import stage_ma_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  ex_ma_reg_t  ex_ma_i,
    output ma_wb_reg_t  ma_wb_reg_o,
    output logic        stall_o,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_rsp_valid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        dmem_err_o
);

    ma_state_e   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    ma_wb_reg_t  ma_wb_q, ma_wb_d;

    logic        mem_op;
    logic        is_store;
    logic        misalign_trap;
    logic        timeout_hit;
    logic [1:0]  a_off;
    logic [31:0] sh;
    logic [31:0] load_fmt;
    ma_wb_reg_t  fwd_wb;
    logic        req_valid, stall, err;

    assign mem_op   = ex_ma_i.instr_valid & (ex_ma_i.dmem_rd_en | ex_ma_i.dmem_wr_en);
    assign is_store = ex_ma_i.dmem_wr_en;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((ex_ma_i.dmem_size == 2'b01) & ex_ma_i.alu_result[0]) |
                        (ex_ma_i.dmem_size[1] & (|ex_ma_i.alu_result[1:0]));
    assign misalign_trap = mem_op & misaligned;
`else
    assign misalign_trap = 1'b0;
`endif

    // Final cycle of a RESP wait; counter holds the number of RESP cycles already spent.
    assign timeout_hit = (RSP_TIMEOUT != 0) && (cnt_q == RSP_TIMEOUT - 1);

    // Byte offset inside the word, forced to natural alignment for half/word.
    always_comb begin
        a_off = 2'b00;
        case (ex_ma_i.dmem_size)
            2'b00:   a_off = ex_ma_i.alu_result[1:0];
            2'b01:   a_off = {ex_ma_i.alu_result[1], 1'b0};
            default: a_off = 2'b00;
        endcase
    end

    assign dmem_addr_o = {ex_ma_i.alu_result[31:2], 2'b00};
    assign dmem_we_o   = is_store;

    // Store lane formatting: data replicated into every lane, enables pick the target.
    always_comb begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = ex_ma_i.dmem_wdata;
        case (ex_ma_i.dmem_size)
            2'b00: begin
                dmem_be_o    = 4'b0001 << a_off;
                dmem_wdata_o = {4{ex_ma_i.dmem_wdata[7:0]}};
            end
            2'b01: begin
                dmem_be_o    = 4'b0011 << a_off;
                dmem_wdata_o = {2{ex_ma_i.dmem_wdata[15:0]}};
            end
            default: begin
                dmem_be_o    = 4'b1111;
                dmem_wdata_o = ex_ma_i.dmem_wdata;
            end
        endcase
    end

    // Load formatting: dmem_sign=1 means zero-extend.
    assign sh = dmem_rdata_i >> {a_off, 3'b000};

    always_comb begin
        load_fmt = sh;
        case (ex_ma_i.dmem_size)
            2'b00:   load_fmt = ex_ma_i.dmem_sign ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_fmt = ex_ma_i.dmem_sign ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_fmt = sh;
        endcase
    end

    // Plain pass-through of the EX-MA fields into MA-WB format.
    always_comb begin
        fwd_wb              = '0;
        fwd_wb.instr_valid  = ex_ma_i.instr_valid;
        fwd_wb.pc_plus_four = ex_ma_i.pc_plus_four;
        fwd_wb.alu_result   = ex_ma_i.alu_result;
        fwd_wb.load_data    = 32'h0;
        fwd_wb.reg_wr_en    = ex_ma_i.reg_wr_en;
        fwd_wb.reg_wr_addr  = ex_ma_i.reg_wr_addr;
    end

    // State register plus the MA-WB register and response timeout counter.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ma_wb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ma_wb_q <= ma_wb_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && !misalign_trap) begin
                    if (dmem_req_ready_i) begin
                        if (!is_store) begin
                            state_d = ST_RESP;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_req_ready_i) begin
                    if (is_store) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RESP: begin
                if (dmem_rsp_valid_i || timeout_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs. A completing access drops stall in the same cycle so EX-MA can
    // advance; otherwise a bubble is written so WB never commits twice.
    always_comb begin
        req_valid           = 1'b0;
        stall               = 1'b0;
        err                 = 1'b0;
        ma_wb_d             = ma_wb_q;
        ma_wb_d.instr_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!mem_op) begin
                    ma_wb_d = fwd_wb;
                end else if (misalign_trap) begin
                    ma_wb_d           = fwd_wb;
                    ma_wb_d.reg_wr_en = 1'b0;
                    err               = 1'b1;
                end else begin
                    req_valid = 1'b1;
                    if (dmem_req_ready_i && is_store) begin
                        ma_wb_d = fwd_wb;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (dmem_req_ready_i && is_store) begin
                    ma_wb_d = fwd_wb;
                end else begin
                    stall = 1'b1;
                end
            end
            ST_RESP: begin
                // A response arriving on the timeout cycle takes priority.
                if (dmem_rsp_valid_i) begin
                    ma_wb_d           = fwd_wb;
                    ma_wb_d.load_data = load_fmt;
                end else if (timeout_hit) begin
                    ma_wb_d           = fwd_wb;
                    ma_wb_d.reg_wr_en = 1'b0;
                    err               = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Gated by reset so a memory op held on ex_ma_i cannot request during reset.
    assign dmem_req_valid_o = req_valid & rst_ni;
    assign stall_o          = stall & rst_ni;
    assign dmem_err_o       = err & rst_ni;
    assign ma_wb_reg_o      = ma_wb_q;

endmodule

// File: tb/tb_stage_ma.sv
// -----------------------------------------------------------------------------
// tb_stage_ma
// Directed self-checking bench for stage_ma (RSP_TIMEOUT=4). Expected MA-WB
// entries are queued when an instruction is driven and compared when the DUT
// retires one. Handshake outputs are checked directly at each step.
// -----------------------------------------------------------------------------
module tb_stage_ma;
    import stage_ma_pkg::*;

    logic        clk;
    logic        rst_ni;
    ex_ma_reg_t  ex;
    ma_wb_reg_t  wb;
    logic        stall;
    logic        req_valid;
    logic        req_ready;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    int          total;
    int          bad;
    logic [31:0] pc_cnt;
    ma_wb_reg_t  exp_q[$];

    stage_ma #(.RSP_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_ni           (rst_ni),
        .ex_ma_i          (ex),
        .ma_wb_reg_o      (wb),
        .stall_o          (stall),
        .dmem_req_valid_o (req_valid),
        .dmem_req_ready_i (req_ready),
        .dmem_we_o        (we),
        .dmem_addr_o      (addr),
        .dmem_be_o        (be),
        .dmem_wdata_o     (wdata),
        .dmem_rsp_valid_i (rsp_valid),
        .dmem_rdata_i     (rdata),
        .dmem_err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("[TB] FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic rd, input logic wr,
                                 input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic rw, input logic [4:0] ra);
        pc_cnt           = pc_cnt + 32'd4;
        ex.instr_valid   = iv;
        ex.pc_plus_four  = pc_cnt;
        ex.alu_result    = a;
        ex.dmem_rd_en    = rd;
        ex.dmem_wr_en    = wr;
        ex.dmem_size     = sz;
        ex.dmem_sign     = sg;
        ex.dmem_wdata    = wd;
        ex.reg_wr_en     = rw;
        ex.reg_wr_addr   = ra;
    endtask

    task automatic applyBubble();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
    endtask

    // Queue the MA-WB entry the currently driven instruction must retire with.
    task automatic expectRetire(input logic [31:0] ld, input logic rw);
        ma_wb_reg_t e;
        e.instr_valid  = 1'b1;
        e.pc_plus_four = ex.pc_plus_four;
        e.alu_result   = ex.alu_result;
        e.load_data    = ld;
        e.reg_wr_en    = rw;
        e.reg_wr_addr  = ex.reg_wr_addr;
        exp_q.push_back(e);
    endtask

    // Reference load formatting, written by lane selection.
    function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz,
                                              input logic zext, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        case (sz)
            2'b00: begin
                case (a[1:0])
                    2'd0:    b = rd[7:0];
                    2'd1:    b = rd[15:8];
                    2'd2:    b = rd[23:16];
                    default: b = rd[31:24];
                endcase
                return zext ? {24'h0, b} : {{24{b[7]}}, b};
            end
            2'b01: begin
                h = a[1] ? rd[31:16] : rd[15:0];
                return zext ? {16'h0, h} : {{16{h[15]}}, h};
            end
            default: return rd;
        endcase
    endfunction

    // Advance one clock; any retirement is matched against the queue head.
    task automatic tickCycle();
        ma_wb_reg_t e;
        @(posedge clk);
        #1;
        if (wb.instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_retire_without_expect", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wb_pc",        wb.pc_plus_four, e.pc_plus_four);
                checkOutput("wb_alu",       wb.alu_result,   e.alu_result);
                checkOutput("wb_load_data", wb.load_data,    e.load_data);
                checkOutput("wb_reg_wr_en", {31'b0, wb.reg_wr_en}, {31'b0, e.reg_wr_en});
                checkOutput("wb_rd",        {27'b0, wb.reg_wr_addr}, {27'b0, e.reg_wr_addr});
            end
        end
    endtask

    task automatic checkBubble(input string tag);
        checkOutput(tag, {31'b0, wb.instr_valid}, 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        pc_cnt    = 32'h0;
        rst_ni    = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rdata     = 32'h0;

        // Reset with a load already sitting on EX-MA.
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 5'd3);
        #2;
        checkOutput("rst_req_valid", {31'b0, req_valid}, 32'd0);
        checkOutput("rst_stall",     {31'b0, stall},     32'd0);
        checkOutput("rst_err",       {31'b0, err},       32'd0);
        checkOutput("rst_wb_valid",  {31'b0, wb.instr_valid}, 32'd0);
        tickCycle();
        tickCycle();
        applyBubble();
        rst_ni = 1'b1;
        $display("[TB] reset released");

        // ALU op passes straight through.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234, 32'h0, 1'b1, 5'd5);
        expectRetire(32'h0, 1'b1);
        #1;
        checkOutput("alu_stall",     {31'b0, stall},     32'd0);
        checkOutput("alu_req_valid", {31'b0, req_valid}, 32'd0);
        tickCycle();

        // SB at 0x103, accepted immediately.
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00AB, 1'b0, 5'd0);
        req_ready = 1'b1;
        expectRetire(32'h0, 1'b0);
        #1;
        checkOutput("sb_req_valid", {31'b0, req_valid}, 32'd1);
        checkOutput("sb_we",        {31'b0, we},        32'd1);
        checkOutput("sb_addr",      addr,               32'h100);
        checkOutput("sb_be",        {28'b0, be},        32'h8);
        checkOutput("sb_wdata",     wdata,              32'hABAB_ABAB);
        tickCycle();
        applyBubble();
        req_ready = 1'b0;
        #1;
        checkOutput("sb_after_stall", {31'b0, stall},     32'd0);
        checkOutput("sb_after_req",   {31'b0, req_valid}, 32'd0);
        tickCycle();

        // LB at 0x102, ready after 2 cycles, response on third RESP cycle.
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 1'b1, 5'd7);
        expectRetire(modelLoad(32'h102, 2'b00, 1'b0, 32'h0080_0000), 1'b1);
        #1;
        checkOutput("lb_idle_req",   {31'b0, req_valid}, 32'd1);
        checkOutput("lb_idle_stall", {31'b0, stall},     32'd1);
        checkOutput("lb_we",         {31'b0, we},        32'd0);
        checkOutput("lb_addr",       addr,               32'h100);
        tickCycle();
        checkBubble("lb_bubble_req1");
        #1;
        checkOutput("lb_req_hold",  {31'b0, req_valid}, 32'd1);
        checkOutput("lb_req_stall", {31'b0, stall},     32'd1);
        tickCycle();
        checkBubble("lb_bubble_req2");
        req_ready = 1'b1;
        #1;
        checkOutput("lb_accept_stall", {31'b0, stall}, 32'd1);
        tickCycle();
        checkBubble("lb_bubble_accept");
        req_ready = 1'b0;
        #1;
        checkOutput("lb_resp_req",   {31'b0, req_valid}, 32'd0);
        checkOutput("lb_resp_stall", {31'b0, stall},     32'd1);
        tickCycle();
        checkBubble("lb_bubble_resp1");
        tickCycle();
        checkBubble("lb_bubble_resp2");
        rsp_valid = 1'b1;
        rdata     = 32'h0080_0000;
        #1;
        checkOutput("lb_rsp_stall", {31'b0, stall}, 32'd0);
        tickCycle();
        rsp_valid = 1'b0;
        applyBubble();

        // LHU at 0x102.
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b1, 5'd9);
        req_ready = 1'b1;
        expectRetire(modelLoad(32'h102, 2'b01, 1'b1, 32'h8001_0000), 1'b1);
        #1;
        checkOutput("lhu_stall", {31'b0, stall}, 32'd1);
        tickCycle();
        req_ready = 1'b0;
        checkBubble("lhu_bubble");
        rsp_valid = 1'b1;
        rdata     = 32'h8001_0000;
        #1;
        checkOutput("lhu_rsp_stall", {31'b0, stall}, 32'd0);
        tickCycle();
        rsp_valid = 1'b0;
        applyBubble();

        // LW with no response: times out on the fourth RESP cycle.
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b1, 5'd10);
        req_ready = 1'b1;
        expectRetire(32'h0, 1'b0);
        tickCycle();
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("to_wait_stall", {31'b0, stall}, 32'd1);
            checkOutput("to_wait_err",   {31'b0, err},   32'd0);
            tickCycle();
            checkBubble("to_wait_bubble");
        end
        #1;
        checkOutput("to_hit_stall", {31'b0, stall}, 32'd0);
        checkOutput("to_hit_err",   {31'b0, err},   32'd1);
        tickCycle();
        applyBubble();
        #1;
        checkOutput("to_err_pulse_end", {31'b0, err}, 32'd0);
        tickCycle();

        // Response arriving on the timeout cycle wins.
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 1'b1, 5'd11);
        req_ready = 1'b1;
        expectRetire(32'hCAFE_F00D, 1'b1);
        tickCycle();
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("race_wait_stall", {31'b0, stall}, 32'd1);
            tickCycle();
        end
        rsp_valid = 1'b1;
        rdata     = 32'hCAFE_F00D;
        #1;
        checkOutput("race_err",   {31'b0, err},   32'd0);
        checkOutput("race_stall", {31'b0, stall}, 32'd0);
        tickCycle();
        rsp_valid = 1'b0;
        applyBubble();
        tickCycle();

        // Misaligned LW at 0x101.
`ifdef DMEM_MISALIGN_TRAP_EN
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1, 5'd12);
        expectRetire(32'h0, 1'b0);
        #1;
        checkOutput("mis_req_valid", {31'b0, req_valid}, 32'd0);
        checkOutput("mis_stall",     {31'b0, stall},     32'd0);
        checkOutput("mis_err",       {31'b0, err},       32'd1);
        tickCycle();
        applyBubble();
        #1;
        checkOutput("mis_err_end", {31'b0, err}, 32'd0);
        tickCycle();
`else
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b1, 5'd12);
        req_ready = 1'b1;
        expectRetire(32'h1122_3344, 1'b1);
        #1;
        checkOutput("mis_req_valid", {31'b0, req_valid}, 32'd1);
        checkOutput("mis_addr",      addr,               32'h100);
        checkOutput("mis_be",        {28'b0, be},        32'hF);
        checkOutput("mis_err",       {31'b0, err},       32'd0);
        tickCycle();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rdata     = 32'h1122_3344;
        tickCycle();
        rsp_valid = 1'b0;
        // Misaligned SH at 0x103 is masked to the upper half.
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h103, 32'h0000_BEEF, 1'b0, 5'd0);
        req_ready = 1'b1;
        expectRetire(32'h0, 1'b0);
        #1;
        checkOutput("mis_sh_be",    {28'b0, be}, 32'hC);
        checkOutput("mis_sh_wdata", wdata,       32'hBEEF_BEEF);
        tickCycle();
        req_ready = 1'b0;
        applyBubble();
        tickCycle();
`endif

        // Asynchronous reset while waiting in RESP.
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b1, 5'd13);
        req_ready = 1'b1;
        tickCycle();
        req_ready = 1'b0;
        #1;
        checkOutput("arst_pre_stall", {31'b0, stall}, 32'd1);
        rst_ni = 1'b0;
        #1;
        checkOutput("arst_stall",     {31'b0, stall},     32'd0);
        checkOutput("arst_req_valid", {31'b0, req_valid}, 32'd0);
        exp_q.delete();
        applyBubble();
        tickCycle();
        rst_ni = 1'b1;

        // Stale response alongside an ALU op must not leak into load_data.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h5678, 32'h0, 1'b1, 5'd14);
        rsp_valid = 1'b1;
        rdata     = 32'hDEAD_BEEF;
        expectRetire(32'h0, 1'b1);
        #1;
        checkOutput("stale_stall", {31'b0, stall}, 32'd0);
        tickCycle();
        rsp_valid = 1'b0;
        applyBubble();
        tickCycle();

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
